// File: rtl/vdp_io_sequencer_if.sv
// CPU-side request/response and vdp18_core CPU-port signals of the I/O sequencer.
// vdp_cd_o/vdp_cd_i use core bit ordering: bit 0 carries the data MSB.
interface vdp_io_sequencer_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       cpu_mode;
    logic [7:0] cpu_d_i;
    logic [7:0] cpu_d_o;
    logic       cpu_rd_valid;
    logic       cpu_wait;
    logic       overflow;
    logic       vdp_csr_n;
    logic       vdp_csw_n;
    logic       vdp_mode;
    logic [7:0] vdp_cd_o;
    logic [7:0] vdp_cd_i;

    modport master (
        output cpu_wr, cpu_rd, cpu_mode, cpu_d_i, vdp_cd_i,
        input  cpu_d_o, cpu_rd_valid, cpu_wait, overflow,
        input  vdp_csr_n, vdp_csw_n, vdp_mode, vdp_cd_o
    );

    modport slave (
        input  cpu_wr, cpu_rd, cpu_mode, cpu_d_i, vdp_cd_i,
        output cpu_d_o, cpu_rd_valid, cpu_wait, overflow,
        output vdp_csr_n, vdp_csw_n, vdp_mode, vdp_cd_o
    );
endinterface

// File: rtl/vdp_io_sequencer.sv
// Buffers Z80 I/O writes and serialised reads, replaying them to the vdp18_core
// CPU port with a fixed strobe width and post-access gap counted in ena ticks.
module vdp_io_sequencer #(
    parameter int FIFO_AW    = 2,
    parameter int STROBE_LEN = 2,
    parameter int GAP_LEN    = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    vdp_io_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    // state  | meaning
    // IDLE   | waiting for a queued write or a pending read
    // SETUP  | mode/data driven, both strobes high
    // STROBE | csw_n (write) or csr_n (read) low for STROBE_LEN ticks
    // HOLD   | strobes released, mode/data held one tick
    // GAP    | enforced idle of GAP_LEN ticks before the next access
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_t;

    state_t           state, state_nxt;
    logic [5:0]       cnt, cnt_nxt;
    logic [8:0]       fifo_mem [DEPTH];
    logic [8:0]       fifo_head;
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic             push, pop, start_rd, capture;
    logic             is_rd, rd_pending, rd_mode;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign push       = bus.cpu_wr && !fifo_full;

    assign bus.cpu_wait  = rd_pending || fifo_full;
    assign bus.vdp_csw_n = !((state == STROBE) && !is_rd);
    assign bus.vdp_csr_n = !((state == STROBE) && is_rd);

    // Reads wait for an empty FIFO so queued writes always reach the VDP first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        start_rd  = 1'b0;
        capture   = 1'b0;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else if (rd_pending) begin
                        start_rd  = 1'b1;
                        state_nxt = SETUP;
                    end
                end
                SETUP: begin
                    state_nxt = STROBE;
                    cnt_nxt   = 6'd0;
                end
                STROBE: begin
                    if (cnt == 6'(STROBE_LEN - 1)) begin
                        state_nxt = HOLD;
                        cnt_nxt   = 6'd0;
                        capture   = is_rd;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                HOLD: begin
                    state_nxt = GAP;
                    cnt_nxt   = 6'd0;
                end
                GAP: begin
                    if (cnt == 6'(GAP_LEN - 1)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 6'd0;
                    end else begin
                        cnt_nxt = cnt + 6'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {bus.cpu_mode, bus.cpu_d_i};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            cnt              <= 6'd0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            is_rd            <= 1'b0;
            rd_pending       <= 1'b0;
            rd_mode          <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.vdp_mode     <= 1'b0;
            bus.vdp_cd_o     <= 8'h00;
            bus.cpu_d_o      <= 8'h00;
            bus.cpu_rd_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            bus.cpu_rd_valid <= capture;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (bus.cpu_wr && fifo_full) bus.overflow <= 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                is_rd        <= 1'b0;
                bus.vdp_mode <= fifo_head[8];
                bus.vdp_cd_o <= bit_rev(fifo_head[7:0]);
            end else if (start_rd) begin
                is_rd        <= 1'b1;
                bus.vdp_mode <= rd_mode;
            end
            if (capture) begin
                bus.cpu_d_o <= bit_rev(bus.vdp_cd_i);
                rd_pending  <= 1'b0;
            end else if (bus.cpu_rd && !rd_pending) begin
                rd_pending <= 1'b1;
                rd_mode    <= bus.cpu_mode;
            end
        end
    end
endmodule
